cpu6_csrfile: RTL and testbench

- Machine-mode CSR register file for cpu6. It is the consumer of the decoder's CSR control outputs (csr, csr_rs1uimm, csr_wsc).
- Performs atomic read/modify/write for CSRRW/CSRRS/CSRRC and their immediate forms.
- Holds trap state (mepc/mcause/mtval/mstatus) and the 64-bit cycle/instret counters.
- Sits in the execute stage next to the ALU. Its read data is muxed onto the register write-back path.

---
 rtl/cpu6_csrfile_if.sv | 25 ++
 rtl/cpu6_csrfile.sv | 165 ++++++++++++++++
 tb/tb_cpu6_csrfile.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu6_csrfile_if.sv
// CSR access bus between the cpu6 decode/execute stage (master) and the CSR file (slave).
`ifndef CPU6_CSR_WSC_SIZE
`define CPU6_CSR_WSC_SIZE 3
`endif

interface cpu6_csrfile_if;
  logic                          csr;
  logic                          csr_rs1uimm;
  logic [`CPU6_CSR_WSC_SIZE-1:0] csr_wsc;
  logic [11:0]                   csr_addr;
  logic [4:0]                    csr_rs1idx;
  logic [31:0]                   rs1_data;
  logic [31:0]                   csr_rdata;
  logic                          csr_illegal;

  modport master (
    output csr, csr_rs1uimm, csr_wsc, csr_addr, csr_rs1idx, rs1_data,
    input  csr_rdata, csr_illegal
  );

  modport slave (
    input  csr, csr_rs1uimm, csr_wsc, csr_addr, csr_rs1idx, rs1_data,
    output csr_rdata, csr_illegal
  );
endinterface

// File: rtl/cpu6_csrfile.sv
// cpu6 machine-mode CSR file: atomic CSRRW/S/C, trap/mret state, optional 64-bit counters.
// Define CPU6_CSR_COUNTERS_EN to implement mcycle/minstret; otherwise their addresses read 0.
`ifndef CPU6_CSR_WSC_SIZE
`define CPU6_CSR_WSC_SIZE 3
`endif

module cpu6_csrfile #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MHARTID     = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  cpu6_csrfile_if.slave        bus,
  input  logic                 instr_retire,
  input  logic                 trap,
  input  logic [31:0]          trap_cause,
  input  logic [31:0]          trap_pc,
  input  logic [31:0]          trap_val,
  input  logic                 mret,
  output logic [31:0]          mtvec_out,
  output logic [31:0]          mepc_out,
  output logic                 mstatus_mie
);

  typedef enum logic [11:0] {
    A_MSTATUS   = 12'h300,
    A_MIE       = 12'h304,
    A_MTVEC     = 12'h305,
    A_MSCRATCH  = 12'h340,
    A_MEPC      = 12'h341,
    A_MCAUSE    = 12'h342,
    A_MTVAL     = 12'h343,
    A_MCYCLE    = 12'hB00,
    A_MINSTRET  = 12'hB02,
    A_MCYCLEH   = 12'hB80,
    A_MINSTRETH = 12'hB82,
    A_CYCLE     = 12'hC00,
    A_INSTRET   = 12'hC02,
    A_CYCLEH    = 12'hC80,
    A_INSTRETH  = 12'hC82,
    A_MHARTID   = 12'hF14
  } csr_addr_e;

  logic        mst_mie, mst_mpie;
  logic [2:0]  mie_bits;
  logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;

  logic        implemented, onehot, suppress, illegal, wr_en;
  logic [31:0] old_val, src, new_val;

`ifdef CPU6_CSR_COUNTERS_EN
  logic [63:0] mcycle_q, minstret_q;
`else
  logic unused_retire;
  assign unused_retire = instr_retire;
`endif

  always_comb begin
    implemented = 1'b1;
    old_val     = '0;
    case (bus.csr_addr)
      A_MSTATUS:  old_val = {19'b0, 2'b11, 3'b0, mst_mpie, 3'b0, mst_mie, 3'b0};
      A_MIE:      old_val = {20'b0, mie_bits[2], 3'b0, mie_bits[1], 3'b0, mie_bits[0], 3'b0};
      A_MTVEC:    old_val = mtvec_q;
      A_MSCRATCH: old_val = mscratch_q;
      A_MEPC:     old_val = mepc_q;
      A_MCAUSE:   old_val = mcause_q;
      A_MTVAL:    old_val = mtval_q;
      A_MHARTID:  old_val = MHARTID;
`ifdef CPU6_CSR_COUNTERS_EN
      A_MCYCLE,   A_CYCLE:    old_val = mcycle_q[31:0];
      A_MCYCLEH,  A_CYCLEH:   old_val = mcycle_q[63:32];
      A_MINSTRET, A_INSTRET:  old_val = minstret_q[31:0];
      A_MINSTRETH, A_INSTRETH: old_val = minstret_q[63:32];
`else
      A_MCYCLE, A_CYCLE, A_MCYCLEH, A_CYCLEH,
      A_MINSTRET, A_INSTRET, A_MINSTRETH, A_INSTRETH: old_val = '0;
`endif
      default:    implemented = 1'b0;
    endcase
  end

  always_comb begin
    src      = bus.csr_rs1uimm ? {27'b0, bus.csr_rs1idx} : bus.rs1_data;
    onehot   = (bus.csr_wsc == 3'b001) || (bus.csr_wsc == 3'b010) || (bus.csr_wsc == 3'b100);
    // Set/clear with x0/uimm 0 is a pure read, so it is allowed on read-only space.
    suppress = (bus.csr_wsc[1] || bus.csr_wsc[2]) && (bus.csr_rs1idx == 5'd0);
    illegal  = bus.csr && (!implemented || !onehot ||
                           (!suppress && (bus.csr_addr[11:10] == 2'b11)));
    wr_en    = bus.csr && !illegal && !suppress && !trap && !mret;
    case (bus.csr_wsc)
      3'b001:  new_val = src;
      3'b010:  new_val = old_val | src;
      3'b100:  new_val = old_val & ~src;
      default: new_val = old_val;
    endcase
  end

  assign bus.csr_rdata   = (bus.csr && !illegal) ? old_val : '0;
  assign bus.csr_illegal = illegal;
  assign mtvec_out       = mtvec_q;
  assign mepc_out        = mepc_q;
  assign mstatus_mie     = mst_mie;

  always_ff @(posedge clk) begin
    if (reset) begin
      mst_mie    <= 1'b0;
      mst_mpie   <= 1'b0;
      mie_bits   <= '0;
      mtvec_q    <= MTVEC_RESET & ~32'd3;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else if (trap) begin
      mepc_q   <= trap_pc & ~32'd3;
      mcause_q <= trap_cause;
      mtval_q  <= trap_val;
      mst_mpie <= mst_mie;
      mst_mie  <= 1'b0;
    end else if (mret) begin
      mst_mie  <= mst_mpie;
      mst_mpie <= 1'b1;
    end else if (wr_en) begin
      case (bus.csr_addr)
        A_MSTATUS: begin
          mst_mie  <= new_val[3];
          mst_mpie <= new_val[7];
        end
        A_MIE:      mie_bits   <= {new_val[11], new_val[7], new_val[3]};
        A_MTVEC:    mtvec_q    <= new_val & ~32'd3;
        A_MSCRATCH: mscratch_q <= new_val;
        A_MEPC:     mepc_q     <= new_val & ~32'd3;
        A_MCAUSE:   mcause_q   <= new_val;
        A_MTVAL:    mtval_q    <= new_val;
        default: ;
      endcase
    end
  end

`ifdef CPU6_CSR_COUNTERS_EN
  // A write to one half replaces the increment for that counter this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (wr_en && (bus.csr_addr == A_MCYCLE))
        mcycle_q[31:0] <= new_val;
      else if (wr_en && (bus.csr_addr == A_MCYCLEH))
        mcycle_q[63:32] <= new_val;
      else
        mcycle_q <= mcycle_q + 64'd1;

      if (wr_en && (bus.csr_addr == A_MINSTRET))
        minstret_q[31:0] <= new_val;
      else if (wr_en && (bus.csr_addr == A_MINSTRETH))
        minstret_q[63:32] <= new_val;
      else if (instr_retire)
        minstret_q <= minstret_q + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu6_csrfile.sv
// Randomized bench for cpu6_csrfile against a behavioural CSR model, plus directed literal checks.
`timescale 1ns/1ps

module tb_cpu6_csrfile;
  localparam logic [31:0] P_MTVEC   = 32'h0000_2003;
  localparam logic [31:0] P_HARTID  = 32'hA5A5_0001;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_retire, trap, mret;
  logic [31:0] trap_cause, trap_pc, trap_val;
  logic [31:0] mtvec_out, mepc_out;
  logic        mstatus_mie;

  cpu6_csrfile_if bus ();

  cpu6_csrfile #(.MTVEC_RESET(P_MTVEC), .MHARTID(P_HARTID)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .instr_retire(instr_retire), .trap(trap), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_val(trap_val), .mret(mret),
    .mtvec_out(mtvec_out), .mepc_out(mepc_out), .mstatus_mie(mstatus_mie)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural CSR contents as seen by software.
  bit          model_ok = 1'b0;
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cycle, m_instret;

  function automatic void m_lookup(input logic [11:0] a, output bit impl, output logic [31:0] v);
    impl = 1'b1;
    v    = 32'h0;
    case (a)
      12'h300: v = m_mstatus | 32'h0000_1800;
      12'h304: v = m_mie;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'hF14: v = P_HARTID;
`ifdef CPU6_CSR_COUNTERS_EN
      12'hB00, 12'hC00: v = m_cycle[31:0];
      12'hB80, 12'hC80: v = m_cycle[63:32];
      12'hB02, 12'hC02: v = m_instret[31:0];
      12'hB82, 12'hC82: v = m_instret[63:32];
`else
      12'hB00, 12'hC00, 12'hB80, 12'hC80,
      12'hB02, 12'hC02, 12'hB82, 12'hC82: v = 32'h0;
`endif
      default: impl = 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    bit          impl, does_write, exp_ill;
    logic [31:0] old, src, nv, exp_rd;
    logic [63:0] ncyc, nins;
    m_lookup(bus.csr_addr, impl, old);
    does_write = (bus.csr_wsc == 3'b001) || (bus.csr_rs1idx != 5'd0);
    exp_ill = bus.csr && (!impl || ($countones(bus.csr_wsc) != 1) ||
                          (does_write && bus.csr_addr >= 12'hC00));
    exp_rd  = (bus.csr && !exp_ill) ? old : 32'h0;
    if (model_ok) begin
      check("csr_rdata",   bus.csr_rdata,                 exp_rd);
      check("csr_illegal", {31'b0, bus.csr_illegal},      {31'b0, exp_ill});
      check("mtvec_out",   mtvec_out,                     m_mtvec);
      check("mepc_out",    mepc_out,                      m_mepc);
      check("mstatus_mie", {31'b0, mstatus_mie},          {31'b0, m_mstatus[3]});
    end
    if (reset) begin
      model_ok   = 1'b1;
      m_mstatus  = 0; m_mie = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
      m_mtvec    = P_MTVEC & ~32'd3;
      m_cycle    = 0; m_instret = 0;
    end else if (model_ok) begin
      ncyc = m_cycle + 64'd1;
      nins = m_instret + 64'(instr_retire);
      if (trap) begin
        m_mepc    = trap_pc & ~32'd3;
        m_mcause  = trap_cause;
        m_mtval   = trap_val;
        m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
      end else if (mret) begin
        m_mstatus = m_mstatus[7] ? 32'h88 : 32'h80;
      end else if (bus.csr && !exp_ill && does_write) begin
        src = bus.csr_rs1uimm ? 32'(bus.csr_rs1idx) : bus.rs1_data;
        if (bus.csr_wsc == 3'b001)      nv = src;
        else if (bus.csr_wsc == 3'b010) nv = old | src;
        else                            nv = old & ~src;
        case (bus.csr_addr)
          12'h300: m_mstatus  = nv & 32'h88;
          12'h304: m_mie      = nv & 32'h888;
          12'h305: m_mtvec    = nv & ~32'd3;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc     = nv & ~32'd3;
          12'h342: m_mcause   = nv;
          12'h343: m_mtval    = nv;
`ifdef CPU6_CSR_COUNTERS_EN
          12'hB00: ncyc = {m_cycle[63:32], nv};
          12'hB80: ncyc = {nv, m_cycle[31:0]};
          12'hB02: nins = {m_instret[63:32], nv};
          12'hB82: nins = {nv, m_instret[31:0]};
`endif
          default: ;
        endcase
      end
      m_cycle   = ncyc;
      m_instret = nins;
    end
  end

  task automatic drive(input bit c, input logic [11:0] a, input logic [2:0] wsc,
                       input bit uimm, input logic [4:0] idx, input logic [31:0] d);
    @(posedge clk); #1;
    reset = 1'b0; trap = 1'b0; mret = 1'b0; instr_retire = 1'b0;
    bus.csr = c; bus.csr_addr = a; bus.csr_wsc = wsc;
    bus.csr_rs1uimm = uimm; bus.csr_rs1idx = idx; bus.rs1_data = d;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 12'h000, 3'b000, 1'b0, 5'd0, 32'h0);
  endtask

  logic [11:0] addrs [0:19] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                12'h343, 12'hF14, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h7C0, 12'h301,
                                12'hC01, 12'h344};

  initial begin
    int unsigned r;
    reset = 1'b1; trap = 1'b0; mret = 1'b0; instr_retire = 1'b0;
    trap_cause = 0; trap_pc = 0; trap_val = 0;
    bus.csr = 0; bus.csr_rs1uimm = 0; bus.csr_wsc = 0; bus.csr_addr = 0;
    bus.csr_rs1idx = 0; bus.rs1_data = 0;
    repeat (2) begin @(posedge clk); #1; reset = 1'b1; end

    idle();
    check("rst_mtvec", mtvec_out, 32'h0000_2000);
    check("rst_mepc",  mepc_out,  32'h0);
    check("rst_mie",   {31'b0, mstatus_mie}, 32'h0);

    drive(1, 12'h340, 3'b001, 0, 5'd7, 32'hDEADBEEF);
    check("mscratch_rw_old", bus.csr_rdata, 32'h0);
    check("mscratch_rw_ill", {31'b0, bus.csr_illegal}, 32'h0);
    drive(1, 12'h340, 3'b010, 0, 5'd0, 32'hFFFF_FFFF);
    check("mscratch_rd", bus.csr_rdata, 32'hDEADBEEF);

    drive(1, 12'h300, 3'b010, 1, 5'd8, 32'h0);
    check("mie_pre_set", {31'b0, mstatus_mie}, 32'h0);
    drive(1, 12'h300, 3'b100, 1, 5'd8, 32'h0);
    check("mstatus_rc", bus.csr_rdata, 32'h0000_1808);
    check("mie_set", {31'b0, mstatus_mie}, 32'h1);
    idle();
    check("mie_clr", {31'b0, mstatus_mie}, 32'h0);

    drive(1, 12'hC00, 3'b001, 0, 5'd3, 32'h5);
    check("ro_write_ill", {31'b0, bus.csr_illegal}, 32'h1);
    check("ro_write_rd",  bus.csr_rdata, 32'h0);
    drive(1, 12'hC00, 3'b010, 0, 5'd0, 32'h5);
    check("ro_read_ill", {31'b0, bus.csr_illegal}, 32'h0);
    drive(1, 12'h7C0, 3'b010, 0, 5'd0, 32'h0);
    check("unimpl_ill", {31'b0, bus.csr_illegal}, 32'h1);
    drive(1, 12'h340, 3'b011, 0, 5'd1, 32'h0);
    check("wsc_ill", {31'b0, bus.csr_illegal}, 32'h1);
    drive(1, 12'hF14, 3'b010, 0, 5'd0, 32'h0);
    check("hartid", bus.csr_rdata, 32'hA5A5_0001);

    drive(1, 12'h300, 3'b010, 1, 5'd8, 32'h0);
    drive(1, 12'h341, 3'b001, 0, 5'd1, 32'h5555_5555);
    trap = 1'b1; trap_pc = 32'h0000_1006; trap_cause = 32'd11; trap_val = 32'h0000_0BAD;
    drive(1, 12'h341, 3'b010, 0, 5'd0, 32'h0);
    check("trap_mepc_rd", bus.csr_rdata, 32'h0000_1004);
    check("trap_mepc_out", mepc_out, 32'h0000_1004);
    check("trap_mie", {31'b0, mstatus_mie}, 32'h0);
    drive(1, 12'h342, 3'b010, 0, 5'd0, 32'h0);
    check("trap_mcause", bus.csr_rdata, 32'd11);
    drive(1, 12'h300, 3'b010, 0, 5'd0, 32'h0);
    check("trap_mstatus", bus.csr_rdata, 32'h0000_1880);
    idle();
    mret = 1'b1;
    idle();
    check("mret_mie", {31'b0, mstatus_mie}, 32'h1);

`ifdef CPU6_CSR_COUNTERS_EN
    drive(1, 12'hB80, 3'b001, 0, 5'd1, 32'h0);
    drive(1, 12'hB00, 3'b001, 0, 5'd1, 32'hFFFF_FFFE);
    idle();
    idle();
    drive(1, 12'hB00, 3'b010, 0, 5'd0, 32'h0);
    check("mcycle_wrap_lo", bus.csr_rdata, 32'h0);
    drive(1, 12'hB80, 3'b010, 0, 5'd0, 32'h0);
    check("mcycle_wrap_hi", bus.csr_rdata, 32'h1);
`else
    drive(1, 12'hB00, 3'b001, 0, 5'd1, 32'h5);
    check("ctr_wr_ill", {31'b0, bus.csr_illegal}, 32'h0);
    drive(1, 12'hB00, 3'b010, 0, 5'd0, 32'h0);
    check("ctr_rd_b00", bus.csr_rdata, 32'h0);
    drive(1, 12'hC00, 3'b010, 0, 5'd0, 32'h0);
    check("ctr_rd_c00", bus.csr_rdata, 32'h0);
`endif

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      drive($urandom_range(0, 9) < 7, addrs[$urandom_range(0, 19)],
            (r < 9) ? (3'b001 << (r % 3)) : 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
            $urandom);
      instr_retire = 1'($urandom_range(0, 1));
      trap         = ($urandom_range(0, 19) == 0);
      mret         = ($urandom_range(0, 14) == 0);
      reset        = ($urandom_range(0, 199) == 0);
      trap_cause   = $urandom;
      trap_pc      = $urandom;
      trap_val     = $urandom;
    end
    idle();
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
